hazard_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage CPU. Drives stall/flush for the PC,
//  IF_ID, ID_EX and EX_MEM registers: load-use bubbles, taken-branch squash,

---
 rtl/hazard_ctrl_pkg.sv | 9 +
 rtl/hazard_ctrl_if.sv | 29 ++
 rtl/hazard_ctrl_irq_sync.sv | 21 ++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/interrupt sequencer.
//   irq_state_t : interrupt entry/exit FSM states
//   RW_DEF      : default register-address width
//   R0          : hard-wired zero register; never the source of a hazard
package hazard_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, DRAIN, INJECT, ISR} irq_state_t;
    localparam int RW_DEF = 4;
    localparam logic [RW_DEF-1:0] R0 = '0;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
//   master : pipeline side (drives decode/execute/memory status, takes controls)
//   slave  : hazard_ctrl side
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int RW = RW_DEF
);
    logic [RW-1:0] id_rs1, id_rs2, ex_reg_dst;
    logic id_use1, id_use2;
    logic ex_reg_wr, ex_wb_sel, ex_br_taken, ex_returni;
    logic mem_busy, irq_req, int_en;
    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic flush_if_id, flush_id_ex, flush_ex_mem;
    logic int_inject, int_ack, in_isr;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2, ex_reg_dst, ex_reg_wr, ex_wb_sel,
               ex_br_taken, ex_returni, mem_busy, irq_req, int_en,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               flush_if_id, flush_id_ex, flush_ex_mem, int_inject, int_ack, in_isr
    );
    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2, ex_reg_dst, ex_reg_wr, ex_wb_sel,
               ex_br_taken, ex_returni, mem_busy, irq_req, int_en,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               flush_if_id, flush_id_ex, flush_ex_mem, int_inject, int_ack, in_isr
    );
endinterface

// File: rtl/hazard_ctrl_irq_sync.sv
// Multi-flop synchroniser for the asynchronous interrupt request level.
//   clk, rst : core clock, async active-high reset (clears the chain)
//   d        : asynchronous input
//   q        : synchronised output, STAGES cycles later
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[STAGES-2:0], d};
    end

    assign q = sync_pipe[STAGES-1];
endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage core: load-use bubbles, taken-branch
// squash, data-memory freeze, and interrupt drain/inject/ISR tracking.
//   clk, rst : core clock, async active-high reset
//   hz       : hazard_ctrl_if.slave -- decode/execute/memory status in,
//              stall/flush/interrupt controls out
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int RW           = RW_DEF,
    parameter int LOAD_BUBBLES = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int IRQ_SYNC     = 2
) (
    input  logic   clk,
    input  logic   rst,
    hazard_ctrl_if.slave hz
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    irq_state_t    state;
    logic [DW-1:0] drain_cnt;
    logic [1:0]    bub_cnt;   // bubbles still owed after the first one
    logic          in_isr_q;
    logic          irq_s;

    logic [RW-1:0] dst;
    logic          busy, br, lu_hit, bub_act, lu_stall, commit;
    logic          s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, inj, ack;

    irq_sync #(.STAGES(IRQ_SYNC)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (hz.irq_req),
        .q   (irq_s)
    );

    assign dst  = hz.ex_reg_dst;
    assign busy = hz.mem_busy;
    assign br   = hz.ex_br_taken;

    assign lu_hit = hz.ex_wb_sel & hz.ex_reg_wr & (dst != RW'(R0)) &
                    ((hz.id_use1 & (hz.id_rs1 == dst)) |
                     (hz.id_use2 & (hz.id_rs2 == dst)));
    assign bub_act  = (bub_cnt != 2'd0);
    // Owed bubbles repeat without re-matching: the load has already left EX.
    assign lu_stall = lu_hit | bub_act;
    // Injection only commits on a cycle where ID actually advances into EX.
    assign commit   = (state == INJECT) & ~busy & ~br & ~lu_stall;

    always_comb begin
        s_pc = 1'b0; s_ifid = 1'b0; s_idex = 1'b0; s_exmem = 1'b0;
        f_ifid = 1'b0; f_idex = 1'b0; inj = 1'b0; ack = 1'b0;
        if (busy) begin
            s_pc = 1'b1; s_ifid = 1'b1; s_idex = 1'b1; s_exmem = 1'b1;
            inj  = (state == INJECT);
        end else if (br) begin
            f_ifid = 1'b1; f_idex = 1'b1;
        end else if (lu_stall) begin
            s_pc = 1'b1; s_ifid = 1'b1; f_idex = 1'b1;
        end else if (state == DRAIN || state == INJECT) begin
            s_pc = 1'b1; f_ifid = 1'b1;
            inj  = commit;
            ack  = commit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            bub_cnt   <= 2'd0;
            in_isr_q  <= 1'b0;
        end else if (!busy) begin
            if (br)          bub_cnt <= 2'd0;
            else if (bub_act) bub_cnt <= bub_cnt - 2'd1;
            else if (lu_hit)  bub_cnt <= 2'(LOAD_BUBBLES - 1);

            case (state)
                IDLE: if (irq_s && hz.int_en && !in_isr_q) begin
                    state     <= DRAIN;
                    drain_cnt <= '0;
                end
                DRAIN: begin
                    if (!hz.int_en)                          state <= IDLE;
                    else if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state <= INJECT;
                    else                                     drain_cnt <= drain_cnt + 1'b1;
                end
                INJECT: if (commit) begin
                    state    <= ISR;
                    in_isr_q <= 1'b1;
                end
                ISR: if (hz.ex_returni) begin
                    state    <= IDLE;
                    in_isr_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gate everything with rst so controls drop immediately on reset, even
    // while mem_busy is asserted.
    assign hz.stall_pc     = ~rst & s_pc;
    assign hz.stall_if_id  = ~rst & s_ifid;
    assign hz.stall_id_ex  = ~rst & s_idex;
    assign hz.stall_ex_mem = ~rst & s_exmem;
    assign hz.flush_if_id  = ~rst & f_ifid;
    assign hz.flush_id_ex  = ~rst & f_idex;
    assign hz.flush_ex_mem = 1'b0;
    assign hz.int_inject   = ~rst & inj;
    assign hz.int_ack      = ~rst & ack;
    assign hz.in_isr       = ~rst & in_isr_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.RW(4)) ha ();
    hazard_ctrl_if #(.RW(4)) hb ();

    hazard_ctrl #(.RW(4), .LOAD_BUBBLES(2), .DRAIN_CYCLES(3), .IRQ_SYNC(2))
        u_a (.clk(clk), .rst(rst), .hz(ha));
    hazard_ctrl #(.RW(4), .LOAD_BUBBLES(1), .DRAIN_CYCLES(3), .IRQ_SYNC(2))
        u_b (.clk(clk), .rst(rst), .hz(hb));

    assign hb.id_rs1 = ha.id_rs1;         assign hb.id_rs2 = ha.id_rs2;
    assign hb.id_use1 = ha.id_use1;       assign hb.id_use2 = ha.id_use2;
    assign hb.ex_reg_dst = ha.ex_reg_dst; assign hb.ex_reg_wr = ha.ex_reg_wr;
    assign hb.ex_wb_sel = ha.ex_wb_sel;   assign hb.ex_br_taken = ha.ex_br_taken;
    assign hb.ex_returni = ha.ex_returni; assign hb.mem_busy = ha.mem_busy;
    assign hb.irq_req = ha.irq_req;       assign hb.int_en = ha.int_en;

    // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
    //  flush_if_id, flush_id_ex, flush_ex_mem, int_inject, int_ack, in_isr}
    logic [9:0] oa, ob;
    assign oa = {ha.stall_pc, ha.stall_if_id, ha.stall_id_ex, ha.stall_ex_mem,
                 ha.flush_if_id, ha.flush_id_ex, ha.flush_ex_mem,
                 ha.int_inject, ha.int_ack, ha.in_isr};
    assign ob = {hb.stall_pc, hb.stall_if_id, hb.stall_id_ex, hb.stall_ex_mem,
                 hb.flush_if_id, hb.flush_id_ex, hb.flush_ex_mem,
                 hb.int_inject, hb.int_ack, hb.in_isr};

    localparam logic [9:0] NONE     = 10'b0000000000;
    localparam logic [9:0] LU       = 10'b1100010000;
    localparam logic [9:0] BUSY     = 10'b1111000000;
    localparam logic [9:0] BR       = 10'b0000110000;
    localparam logic [9:0] HOLD     = 10'b1000100000;
    localparam logic [9:0] INJ      = 10'b1000100110;
    localparam logic [9:0] INJ_BUSY = 10'b1111000100;
    localparam logic [9:0] ISR      = 10'b0000000001;
    localparam logic [9:0] ISR_BUSY = 10'b1111000001;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ha.id_rs1 = '0; ha.id_rs2 = '0; ha.id_use1 = 1'b0; ha.id_use2 = 1'b0;
        ha.ex_reg_dst = '0; ha.ex_reg_wr = 1'b0; ha.ex_wb_sel = 1'b0;
        ha.ex_br_taken = 1'b0; ha.ex_returni = 1'b0; ha.mem_busy = 1'b0;
    endtask

    task automatic lu3();
        ha.ex_wb_sel = 1'b1; ha.ex_reg_wr = 1'b1; ha.ex_reg_dst = 4'd3;
        ha.id_rs1 = 4'd3; ha.id_use1 = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        ha.irq_req = 1'b0; ha.int_en = 1'b0;
        ha.mem_busy = 1'b1;
        #2;
        chk("reset_gate_a", oa, NONE);
        chk("reset_gate_b", ob, NONE);
        ha.mem_busy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick(); #1 chk("idle", oa, NONE);

        // Load-use: 2 bubbles on a, 1 on b
        lu3(); #1 chk("lu_a0", oa, LU); chk("lu_b0", ob, LU);
        tick(); clr(); #1 chk("lu_a1", oa, LU); chk("lu_b1", ob, NONE);
        tick(); #1 chk("lu_a2", oa, NONE);
        ha.ex_wb_sel = 1'b1; ha.ex_reg_wr = 1'b1; ha.ex_reg_dst = 4'd0;
        ha.id_rs1 = 4'd0; ha.id_use1 = 1'b1;
        #1 chk("lu_r0", oa, NONE);
        clr(); lu3(); ha.ex_wb_sel = 1'b0;
        #1 chk("lu_not_load", oa, NONE);
        clr(); ha.ex_wb_sel = 1'b1; ha.ex_reg_wr = 1'b1; ha.ex_reg_dst = 4'd5;
        ha.id_rs1 = 4'd1; ha.id_use1 = 1'b1; ha.id_rs2 = 4'd5; ha.id_use2 = 1'b0;
        #1 chk("lu_rs2_unused", oa, NONE);
        ha.id_use2 = 1'b1;
        #1 chk("lu_rs2", oa, LU);
        tick(); clr(); #1 chk("lu_rs2_b2", oa, LU);
        tick(); #1 chk("lu_rs2_done", oa, NONE);

        // Branch beats load-use and cancels owed bubbles
        lu3(); ha.ex_br_taken = 1'b1; #1 chk("br_over_lu", oa, BR);
        tick(); clr(); #1 chk("br_no_bubble", oa, NONE);
        lu3(); #1 chk("lu_then_br0", oa, LU);
        tick(); clr(); ha.ex_br_taken = 1'b1; #1 chk("lu_then_br1", oa, BR);
        tick(); clr(); #1 chk("br_cancelled", oa, NONE);

        // mem_busy freezes the bubble sequence
        lu3(); #1 chk("busy_lu0", oa, LU);
        tick(); clr(); ha.mem_busy = 1'b1; #1 chk("busy_c0", oa, BUSY);
        for (int i = 1; i < 4; i++) begin
            tick(); #1 chk($sformatf("busy_c%0d", i), oa, BUSY);
        end
        tick(); ha.mem_busy = 1'b0; #1 chk("busy_resume", oa, LU);
        tick(); #1 chk("busy_done", oa, NONE);

        // Interrupt entry and exit
        ha.int_en = 1'b1; ha.irq_req = 1'b1; #1 chk("irq_t0", oa, NONE);
        tick(); ha.irq_req = 1'b0; #1 chk("irq_t1", oa, NONE);
        tick(); #1 chk("irq_t2", oa, NONE);
        tick(); #1 chk("drain0", oa, HOLD);
        tick(); #1 chk("drain1", oa, HOLD);
        tick(); #1 chk("drain2", oa, HOLD);
        tick(); #1 chk("inject", oa, INJ);
        tick(); #1 chk("isr", oa, ISR);
        ha.irq_req = 1'b1;
        tick(); ha.irq_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); #1 chk($sformatf("isr_ignore%0d", i), oa, ISR);
        end
        ha.ex_returni = 1'b1; ha.mem_busy = 1'b1; #1 chk("reti_busy", oa, ISR_BUSY);
        tick(); ha.mem_busy = 1'b0; #1 chk("reti", oa, ISR);
        tick(); ha.ex_returni = 1'b0; #1 chk("reti_done", oa, NONE);
        tick(); #1 chk("idle_after_isr", oa, NONE);

        // int_en dropped during DRAIN
        ha.irq_req = 1'b1;
        tick(); ha.irq_req = 1'b0;
        tick();
        tick(); #1 chk("abort_drain0", oa, HOLD);
        tick(); ha.int_en = 1'b0; #1 chk("abort_drain1", oa, HOLD);
        for (int i = 0; i < 3; i++) begin
            tick(); #1 chk($sformatf("abort_idle%0d", i), oa, NONE);
        end

        // Reset while in ISR
        ha.int_en = 1'b1; ha.irq_req = 1'b1;
        tick(); ha.irq_req = 1'b0;
        repeat (5) tick();
        #1 chk("rst_pre_inj", oa, INJ);
        tick(); #1 chk("rst_pre_isr", oa, ISR);
        #2 rst = 1'b1; ha.mem_busy = 1'b1;
        #1 chk("rst_async_a", oa, NONE); chk("rst_async_b", ob, NONE);
        tick(); #1 chk("rst_held", oa, NONE);
        rst = 1'b0; ha.mem_busy = 1'b0;
        tick(); #1 chk("rst_released", oa, NONE);

        // Branch and mem_busy during INJECT
        ha.irq_req = 1'b1;
        tick(); ha.irq_req = 1'b0;
        tick(); tick();
        #1 chk("inj_drain0", oa, HOLD);
        tick(); tick(); tick();
        ha.ex_br_taken = 1'b1; #1 chk("inj_br", oa, BR);
        tick(); ha.ex_br_taken = 1'b0; ha.mem_busy = 1'b1; #1 chk("inj_busy0", oa, INJ_BUSY);
        tick(); #1 chk("inj_busy1", oa, INJ_BUSY);
        tick(); ha.mem_busy = 1'b0; #1 chk("inj_release", oa, INJ);
        tick(); #1 chk("inj_isr", oa, ISR);
        ha.ex_returni = 1'b1;
        tick(); ha.ex_returni = 1'b0; #1 chk("inj_exit", oa, NONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
